loopback_checker: RTL and testbench

LOOPBACK_CHECKER -- requirements
Module: loopback_checker

---
 rtl/loopback_pkg.sv | 22 ++
 rtl/loopback_checker_if.sv | 28 ++
 rtl/loopback_expect.sv | 28 ++
 rtl/loopback_checker.sv | 129 ++++++++++++
 tb/tb_loopback_checker.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/loopback_pkg.sv
// Shared definitions for the loopback checker: FSM states, LFSR constants
// and the LFSR step function.
package loopback_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DRIVE = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;  // x^16+x^14+x^13+x^11+1
    localparam logic [15:0] NO_FAIL   = 16'hFFFF;

    // One right-shifting Galois step; taps fold in when bit 0 falls out.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/loopback_checker_if.sv
// Control, status and loopback bus of the checker. The master side is the
// checker itself; the slave side is the test harness plus the looped design.
interface loopback_checker_if #(
    parameter int INPUT_BITS  = 16,
    parameter int OUTPUT_BITS = 8
);
    logic                   start;
    logic [15:0]            num_vectors;
    logic [3:0]             settle;
    logic [INPUT_BITS-1:0]  dut_in;
    logic                   dut_rst_n;
    logic [OUTPUT_BITS-1:0] dut_out;
    logic                   busy;
    logic                   done;
    logic                   pass;
    logic [15:0]            err_count;
    logic [15:0]            first_fail_idx;

    modport master (
        input  start, num_vectors, settle, dut_out,
        output dut_in, dut_rst_n, busy, done, pass, err_count, first_fail_idx
    );

    modport slave (
        output start, num_vectors, settle, dut_out,
        input  dut_in, dut_rst_n, busy, done, pass, err_count, first_fail_idx
    );
endinterface

// File: rtl/loopback_expect.sv
// Expected response of the looped design: a running XOR starting from the
// reset-polarity bit and folding in dut_in one bit at a time. Response bit j
// sees the prefix that ends at input bit INPUT_BITS-OUTPUT_BITS+j. Bit 0 is
// the looped clock and has no expectation, so it is tied low.
module loopback_expect
    import loopback_pkg::*;
#(
    parameter int INPUT_BITS  = 16,
    parameter int OUTPUT_BITS = 8
) (
    input  logic [INPUT_BITS-1:0]  dut_in,
    input  logic                   dut_rst_n,
    output logic [OUTPUT_BITS-1:0] expected
);

    // Walk the prefix chain and tap the top OUTPUT_BITS-1 links.
    always_comb begin : prefix_xor
        logic acc;
        acc      = dut_rst_n;
        expected = '0;
        for (int k = 0; k < INPUT_BITS; k++) begin
            acc = acc ^ dut_in[k];
            if (k + 1 >= INPUT_BITS - OUTPUT_BITS + 2)
                expected[k + 1 - (INPUT_BITS - OUTPUT_BITS + 1)] = acc;
        end
    end

endmodule

// File: rtl/loopback_checker.sv
// Loopback checker: drives LFSR vectors into an external design, waits a
// programmable settle time, compares the response against the prefix-XOR
// model and accumulates an error count and the first failing index.
module loopback_checker
    import loopback_pkg::*;
#(
    parameter int INPUT_BITS  = 16,
    parameter int OUTPUT_BITS = 8
) (
    input  logic clk,
    input  logic rst,
    loopback_checker_if.master bus
);

    // Bit 0 of the response is the looped clock; never compare it.
    localparam logic [OUTPUT_BITS-1:0] CMP_MASK = {{(OUTPUT_BITS-1){1'b1}}, 1'b0};

    state_t                  state;
    logic [15:0]             lfsr;
    logic [15:0]             vec_idx;
    logic [15:0]             nv_q;
    logic [3:0]              settle_q;
    logic [3:0]              wait_cnt;
    logic [INPUT_BITS-1:0]   dut_in_q;
    logic                    dut_rst_n_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    pass_q;
    logic [15:0]             err_q;
    logic [15:0]             ffi_q;
    logic [OUTPUT_BITS-1:0]  expected;
    logic                    mismatch;

    // Expectation is formed from the registered drive values, not the LFSR.
    loopback_expect #(
        .INPUT_BITS  (INPUT_BITS),
        .OUTPUT_BITS (OUTPUT_BITS)
    ) u_expect (
        .dut_in    (dut_in_q),
        .dut_rst_n (dut_rst_n_q),
        .expected  (expected)
    );

    assign mismatch = |((bus.dut_out ^ expected) & CMP_MASK);

    // Sequencer: accept start, drive, settle, check, and account errors.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            lfsr        <= LFSR_SEED;
            vec_idx     <= '0;
            nv_q        <= '0;
            settle_q    <= '0;
            wait_cnt    <= '0;
            dut_in_q    <= '0;
            dut_rst_n_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_q       <= '0;
            ffi_q       <= NO_FAIL;
        end else begin
            unique case (state)
                // DONE reacts to start exactly like IDLE.
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        lfsr     <= LFSR_SEED;
                        vec_idx  <= '0;
                        err_q    <= '0;
                        ffi_q    <= NO_FAIL;
                        nv_q     <= bus.num_vectors;
                        settle_q <= bus.settle;
                        if (bus.num_vectors == 16'd0) begin
                            state  <= S_DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            pass_q <= 1'b1;
                        end else begin
                            state  <= S_DRIVE;
                            busy_q <= 1'b1;
                            done_q <= 1'b0;
                            pass_q <= 1'b0;
                        end
                    end
                end
                S_DRIVE: begin
                    dut_in_q    <= lfsr[INPUT_BITS-1:0];
                    dut_rst_n_q <= ~vec_idx[0];
                    lfsr        <= lfsr_next(lfsr);
                    if (settle_q == 4'd0) begin
                        state <= S_CHECK;
                    end else begin
                        wait_cnt <= settle_q - 4'd1;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 4'd0) state <= S_CHECK;
                    else                  wait_cnt <= wait_cnt - 4'd1;
                end
                S_CHECK: begin
                    if (mismatch) begin
                        if (err_q != 16'hFFFF) err_q <= err_q + 16'd1;
                        if (ffi_q == NO_FAIL)  ffi_q <= vec_idx;
                    end
                    if (vec_idx + 16'd1 == nv_q) begin
                        state  <= S_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        pass_q <= !mismatch && (err_q == 16'd0);
                    end else begin
                        vec_idx <= vec_idx + 16'd1;
                        state   <= S_DRIVE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.dut_in         = dut_in_q;
    assign bus.dut_rst_n      = dut_rst_n_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.pass           = pass_q;
    assign bus.err_count      = err_q;
    assign bus.first_fail_idx = ffi_q;

endmodule

// File: tb/tb_loopback_checker.sv
// Bench for loopback_checker: an ideal / delayed / stuck-bit loopback model
// on dut_out, and a vector-level reference that predicts error count, first
// failing index, completion latency and the last driven stimulus.
module tb_loopback_checker;

    localparam int IB = 16;
    localparam int OB = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    loopback_checker_if #(.INPUT_BITS(IB), .OUTPUT_BITS(OB)) bus();

    loopback_checker #(.INPUT_BITS(IB), .OUTPUT_BITS(OB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Loopback model configuration.
    bit       delay_en  = 1'b0;
    bit       stuck_en  = 1'b0;
    int       stuck_bit = 3;
    bit       stuck_val = 1'b0;
    logic [OB-1:0] d1 = '0, d2 = '0, d3 = '0;

    // Snapshot taken one cycle after the start edge.
    logic [15:0] snap_err;
    logic        snap_busy, snap_done;

    // Response bit j = parity of reset-polarity bit and the low (IB-OB+1+j) inputs.
    function automatic logic [OB-1:0] ideal_resp(input logic [IB-1:0] din, input logic rn);
        logic [OB-1:0] r;
        logic [IB-1:0] m;
        r = '0;
        for (int j = 1; j < OB; j++) begin
            m    = {IB{1'b1}} >> (OB - 1 - j);
            r[j] = rn ^ (^(din & m));
        end
        return r;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    always @(posedge clk) begin
        d1 <= ideal_resp(bus.dut_in, bus.dut_rst_n);
        d2 <= d1;
        d3 <= d2;
    end

    always_comb begin : loop_model
        logic [OB-1:0] r;
        r = delay_en ? d3 : ideal_resp(bus.dut_in, bus.dut_rst_n);
        if (stuck_en) r[stuck_bit] = stuck_val;
        r[0] = clk;
        bus.dut_out = r;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Whole-run prediction from the current loopback model configuration.
    task automatic predict(input int nv, output int e_err, output int e_ffi,
                           output logic [15:0] last_din, output logic last_rn);
        logic [15:0]   s;
        logic [OB-1:0] e, o;
        s = 16'hACE1; e_err = 0; e_ffi = 16'hFFFF;
        last_din = bus.dut_in; last_rn = bus.dut_rst_n;
        for (int i = 0; i < nv; i++) begin
            last_din = s;
            last_rn  = (i % 2 == 0);
            e = ideal_resp(last_din, last_rn);
            o = e;
            if (stuck_en) o[stuck_bit] = stuck_val;
            if (o[OB-1:1] != e[OB-1:1]) begin
                if (e_err < 16'hFFFF) e_err++;
                if (e_ffi == 16'hFFFF) e_ffi = i;
            end
            s = lfsr_step(s);
        end
    endtask

    // Pulse start, then wait (bounded) for done; inj>=0 pulses start again mid-run.
    task automatic run(input int nv, input int st, input int inj, output int cycles);
        bus.num_vectors = 16'(nv);
        bus.settle      = 4'(st);
        bus.start       = 1'b1;
        @(posedge clk); #1;
        bus.start       = 1'b0;
        bus.num_vectors = 16'($urandom);
        bus.settle      = 4'($urandom);
        snap_err  = bus.err_count;
        snap_busy = bus.busy;
        snap_done = bus.done;
        cycles = 0;
        while (bus.done !== 1'b1 && cycles < nv * (st + 2) + 20) begin
            bus.start = (cycles == inj);
            @(posedge clk); #1;
            cycles++;
        end
        bus.start = 1'b0;
    endtask

    task automatic run_and_check(input string tag, input int nv, input int st, input int inj);
        int          cyc, e_err, e_ffi;
        logic [15:0] l_din;
        logic        l_rn;
        predict(nv, e_err, e_ffi, l_din, l_rn);
        run(nv, st, inj, cyc);
        chk({tag, ".latency"}, cyc, nv * (st + 2));
        chk({tag, ".done"}, bus.done, 1);
        chk({tag, ".busy"}, bus.busy, 0);
        chk({tag, ".pass"}, bus.pass, (e_err == 0));
        chk({tag, ".err"}, bus.err_count, e_err);
        chk({tag, ".ffi"}, bus.first_fail_idx, e_ffi);
        chk({tag, ".din"}, bus.dut_in, l_din);
        chk({tag, ".rstn"}, bus.dut_rst_n, l_rn);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".din"}, bus.dut_in, 0);
        chk({tag, ".rstn"}, bus.dut_rst_n, 0);
        chk({tag, ".busy"}, bus.busy, 0);
        chk({tag, ".done"}, bus.done, 0);
        chk({tag, ".pass"}, bus.pass, 0);
        chk({tag, ".err"}, bus.err_count, 0);
        chk({tag, ".ffi"}, bus.first_fail_idx, 16'hFFFF);
    endtask

    initial begin
        int cyc;
        bus.start = 1'b0; bus.num_vectors = '0; bus.settle = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");
        rst = 1'b0;

        // Ideal loopback, 100 vectors, no settle.
        run_and_check("ideal100", 100, 0, -1);

        // Zero-length run completes immediately and leaves the stimulus alone.
        run_and_check("zero", 0, 0, -1);

        // Response delayed three cycles: enough settle passes, none fails.
        delay_en = 1'b1;
        run(30, 3, -1, cyc);
        chk("dly3.latency", cyc, 150);
        chk("dly3.pass", bus.pass, 1);
        chk("dly3.err", bus.err_count, 0);
        run(30, 0, -1, cyc);
        chk("dly0.latency", cyc, 60);
        chk("dly0.errnz", (bus.err_count != 16'd0), 1);
        chk("dly0.pass", bus.pass, 0);
        delay_en = 1'b0;

        // Response bit 3 stuck low.
        stuck_en = 1'b1; stuck_bit = 3; stuck_val = 1'b0;
        run_and_check("stuck3", 50, 0, -1);

        // Start during busy is ignored; start in DONE begins a fresh run.
        run_and_check("ignore", 10, 1, 7);
        stuck_en = 1'b0;
        run_and_check("restart", 5, 0, -1);
        chk("restart.snap_err", snap_err, 0);
        chk("restart.snap_busy", snap_busy, 1);
        chk("restart.snap_done", snap_done, 0);

        // Reset in the middle of vector 7 of 20, then a clean rerun.
        bus.num_vectors = 16'd20; bus.settle = 4'd0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset("midrst");
        rst = 1'b0;
        run_and_check("rerun", 20, 0, -1);

        // Randomized runs: length, settle, fault and stray start pulses.
        for (int r = 0; r < 8; r++) begin
            stuck_en  = 1'($urandom_range(0, 1));
            stuck_bit = $urandom_range(1, OB - 1);
            stuck_val = 1'($urandom_range(0, 1));
            run_and_check($sformatf("rand%0d", r), $urandom_range(1, 40),
                          $urandom_range(0, 4), $urandom_range(0, 60) - 10);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
